// File: rtl/brushless_pkg.sv
// Shared types and helpers for the six-step BLDC commutator: phase select codes,
// FSM states, Hall step codes and the Hall-to-phase decode.
package brushless_pkg;

  typedef enum logic [1:0] {
    PH_HIGH_Z  = 2'b00,
    PH_FORWARD = 2'b01,
    PH_REVERSE = 2'b10,
    PH_BRAKE   = 2'b11
  } phase_sel_t;

  typedef struct packed {
    phase_sel_t grn;
    phase_sel_t ylw;
    phase_sel_t blu;
  } phase_set_t;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DEAD  = 2'b01,
    BRAKE = 2'b10,
    FAULT = 2'b11
  } comm_state_t;

  // Forward electrical rotation order of the Hall code {grn,ylw,blu}
  localparam logic [2:0] HALL_S0 = 3'b101;
  localparam logic [2:0] HALL_S1 = 3'b100;
  localparam logic [2:0] HALL_S2 = 3'b110;
  localparam logic [2:0] HALL_S3 = 3'b010;
  localparam logic [2:0] HALL_S4 = 3'b011;
  localparam logic [2:0] HALL_S5 = 3'b001;

  localparam phase_set_t ALL_HIGH_Z = '{PH_HIGH_Z, PH_HIGH_Z, PH_HIGH_Z};
  localparam phase_set_t ALL_BRAKE  = '{PH_BRAKE, PH_BRAKE, PH_BRAKE};

  function automatic logic hall_valid(input logic [2:0] hall);
    return (hall != 3'b000) && (hall != 3'b111);
  endfunction

  function automatic logic [2:0] hall_pos(input logic [2:0] hall);
    case (hall)
      HALL_S0: return 3'd0;
      HALL_S1: return 3'd1;
      HALL_S2: return 3'd2;
      HALL_S3: return 3'd3;
      HALL_S4: return 3'd4;
      HALL_S5: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [2:0] pos_next(input logic [2:0] pos);
    return (pos == 3'd5) ? 3'd0 : pos + 3'd1;
  endfunction

  function automatic logic hall_adjacent(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] pa;
    logic [2:0] pb;
    pa = hall_pos(a);
    pb = hall_pos(b);
    return (pos_next(pa) == pb) || (pos_next(pb) == pa);
  endfunction

  function automatic phase_sel_t flip_dir(input phase_sel_t p);
    case (p)
      PH_FORWARD: return PH_REVERSE;
      PH_REVERSE: return PH_FORWARD;
      default:    return p;
    endcase
  endfunction

  function automatic phase_set_t hall_decode(input logic [2:0] hall, input logic dir);
    phase_set_t p;
    case (hall)
      HALL_S0: p = '{PH_FORWARD, PH_REVERSE, PH_HIGH_Z};
      HALL_S1: p = '{PH_FORWARD, PH_HIGH_Z, PH_REVERSE};
      HALL_S2: p = '{PH_HIGH_Z, PH_FORWARD, PH_REVERSE};
      HALL_S3: p = '{PH_REVERSE, PH_FORWARD, PH_HIGH_Z};
      HALL_S4: p = '{PH_REVERSE, PH_HIGH_Z, PH_FORWARD};
      HALL_S5: p = '{PH_HIGH_Z, PH_REVERSE, PH_FORWARD};
      default: p = ALL_HIGH_Z;
    endcase
    if (dir) begin
      p.grn = flip_dir(p.grn);
      p.ylw = flip_dir(p.ylw);
      p.blu = flip_dir(p.blu);
    end else begin
      p = p;
    end
    return p;
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Hall input synchroniser plus debounce: a synchronised code is accepted into
// hall_q only after FILT_CYC stable cycles; hall_chg pulses when hall_q changes.
module hall_filter
  import brushless_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_raw,
  output logic [2:0] hall_q,
  output logic       hall_chg
);

  localparam int CNT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [CNT_W-1:0] STAB_MAX = CNT_W'((FILT_CYC > 0) ? FILT_CYC - 1 : 0);

  logic [SYNC_STAGES-1:0][2:0] sync_r;
  logic [2:0]       cand_s;
  logic [2:0]       last_r;
  logic [CNT_W-1:0] stab_r;
  logic             load_s;
  logic [2:0]       hall_r;
  logic             chg_r;

  assign cand_s = sync_r[SYNC_STAGES-1];

  generate
    if (FILT_CYC == 0) begin : g_bypass
      assign load_s = 1'b1;
    end else begin : g_filter
      assign load_s = (cand_s == last_r) && (stab_r == STAB_MAX);
    end
  endgenerate

  // Synchroniser chain and stability counter; counter saturates once stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '{default: 3'b000};
      last_r <= 3'b000;
      stab_r <= {CNT_W{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], hall_raw};
      if (cand_s != last_r) begin
        last_r <= cand_s;
        stab_r <= {CNT_W{1'b0}};
      end else if (stab_r != STAB_MAX) begin
        stab_r <= stab_r + CNT_W'(1);
      end else begin
        stab_r <= stab_r;
      end
    end
  end

  // Accepted Hall code and its one-cycle change strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hall_r <= 3'b000;
      chg_r  <= 1'b0;
    end else if (load_s) begin
      hall_r <= cand_s;
      chg_r  <= (cand_s != hall_r);
    end else begin
      hall_r <= hall_r;
      chg_r  <= 1'b0;
    end
  end

  assign hall_q   = hall_r;
  assign hall_chg = chg_r;

endmodule

// File: rtl/brushless_commutator.sv
// Six-step BLDC commutator: filtered Hall decode, dead-time, brake, invalid-Hall fault.
// Optional build macro HALL_SEQ_CHECK_EN faults on non-adjacent Hall steps.
module brushless_commutator
  import brushless_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 3,
  parameter int DEAD_CYC    = 4,
  parameter int BAD_LIMIT   = 64,
  parameter int MAG_W       = 12,
  parameter int DUTY_W      = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hallGrn,
  input  logic              hallYlw,
  input  logic              hallBlu,
  input  logic              brake_n,
  input  logic              dir,
  input  logic              clr_fault,
  input  logic [MAG_W-1:0]  drv_mag,
  output logic [1:0]        selGrn,
  output logic [1:0]        selYlw,
  output logic [1:0]        selBlu,
  output logic [DUTY_W-1:0] duty,
  output logic              fault
);

  localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYC);
  localparam logic [DEAD_W-1:0] DEAD_ONE  = DEAD_W'(1);
  localparam logic              USE_DEAD  = (DEAD_CYC > 0);
  localparam int BAD_W = $clog2(BAD_LIMIT + 1);
  localparam logic [BAD_W-1:0] BAD_MAX = BAD_W'(BAD_LIMIT);
  localparam logic [DUTY_W-1:0] BRAKE_DUTY = {2'b11, {(DUTY_W-2){1'b0}}};

  logic [2:0]        hall_q;
  logic              hall_chg;
  logic [2:0]        hall_d_r;
  comm_state_t       state_r, state_s;
  logic [DEAD_W-1:0] dead_r, dead_s;
  logic [BAD_W-1:0]  bad_r, bad_s;
  phase_set_t        sel_r, sel_s, dec_s;
  logic [DUTY_W-1:0] duty_r, duty_s, run_duty_s;
  logic              fault_r;
  logic              valid_s, commute_s, seq_err_s;
  logic              mag_unused_s;

  hall_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_CYC    (FILT_CYC)
  ) u_hall_filter (
    .clk      (clk),
    .rst      (rst),
    .hall_raw ({hallGrn, hallYlw, hallBlu}),
    .hall_q   (hall_q),
    .hall_chg (hall_chg)
  );

  assign valid_s      = hall_valid(hall_q);
  assign dec_s        = hall_decode(hall_q, dir);
  // Only a valid-to-valid step is a commutation; leaving an invalid code drives at once
  assign commute_s    = hall_chg && valid_s && hall_valid(hall_d_r);
  assign run_duty_s   = {1'b1, drv_mag[MAG_W-1 -: DUTY_W-1]};
  assign mag_unused_s = ^drv_mag;

`ifdef HALL_SEQ_CHECK_EN
  assign seq_err_s = commute_s && !hall_adjacent(hall_d_r, hall_q);
`else
  assign seq_err_s = 1'b0;
`endif

  // Next-state, counters and next registered outputs
  always_comb begin
    state_s = state_r;
    dead_s  = dead_r;
    bad_s   = bad_r;
    sel_s   = ALL_HIGH_Z;
    duty_s  = run_duty_s;
    case (state_r)
      RUN, DEAD: begin
        if (valid_s) begin
          bad_s = {BAD_W{1'b0}};
        end else if (bad_r != BAD_MAX) begin
          bad_s = bad_r + BAD_W'(1);
        end else begin
          bad_s = bad_r;
        end
        if ((bad_s == BAD_MAX) || seq_err_s) begin
          state_s = FAULT;
        end else if (!brake_n) begin
          state_s = BRAKE;
        end else if (commute_s && USE_DEAD) begin
          state_s = DEAD;
          dead_s  = DEAD_LOAD;
        end else if (state_r == DEAD) begin
          if (dead_r <= DEAD_ONE) begin
            state_s = RUN;
            dead_s  = {DEAD_W{1'b0}};
            sel_s   = dec_s;
          end else begin
            dead_s = dead_r - DEAD_ONE;
          end
        end else begin
          sel_s = dec_s;
        end
      end
      BRAKE: begin
        bad_s = {BAD_W{1'b0}};
        if (!brake_n) begin
          state_s = BRAKE;
        end else if (USE_DEAD) begin
          state_s = DEAD;
          dead_s  = DEAD_LOAD;
        end else begin
          state_s = RUN;
          sel_s   = dec_s;
        end
      end
      FAULT: begin
        bad_s = {BAD_W{1'b0}};
        if (clr_fault && valid_s && USE_DEAD) begin
          state_s = DEAD;
          dead_s  = DEAD_LOAD;
        end else if (clr_fault && valid_s) begin
          state_s = RUN;
          sel_s   = dec_s;
        end else begin
          state_s = FAULT;
        end
      end
      default: begin
        state_s = FAULT;
        bad_s   = {BAD_W{1'b0}};
      end
    endcase
    if (!brake_n) begin
      sel_s  = ALL_BRAKE;
      duty_s = BRAKE_DUTY;
    end else if (state_s == FAULT) begin
      sel_s  = ALL_HIGH_Z;
      duty_s = {DUTY_W{1'b0}};
    end else begin
      duty_s = run_duty_s;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= RUN;
      dead_r   <= {DEAD_W{1'b0}};
      bad_r    <= {BAD_W{1'b0}};
      sel_r    <= ALL_HIGH_Z;
      duty_r   <= {DUTY_W{1'b0}};
      fault_r  <= 1'b0;
      hall_d_r <= 3'b000;
    end else begin
      state_r  <= state_s;
      dead_r   <= dead_s;
      bad_r    <= bad_s;
      sel_r    <= sel_s;
      duty_r   <= duty_s;
      fault_r  <= (state_s == FAULT);
      hall_d_r <= hall_q;
    end
  end

  assign selGrn = sel_r.grn;
  assign selYlw = sel_r.ylw;
  assign selBlu = sel_r.blu;
  assign duty   = duty_r;
  assign fault  = fault_r;

endmodule

// File: tb/tb_brushless_commutator.sv
// Directed bench for brushless_commutator at default parameters; expected values
// are hand-derived from the commutation table and edge-count latencies.
module tb_brushless_commutator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hall;
  logic        brake_n;
  logic        dir;
  logic        clr_fault;
  logic [11:0] drv_mag;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic [10:0] duty;
  logic        fault;
  logic [5:0]  sel_v;

  int checks = 0;
  int errors = 0;

  assign sel_v = {selGrn, selYlw, selBlu};

  always #5 clk = ~clk;

  brushless_commutator dut (
    .clk       (clk),
    .rst       (rst),
    .hallGrn   (hall[2]),
    .hallYlw   (hall[1]),
    .hallBlu   (hall[0]),
    .brake_n   (brake_n),
    .dir       (dir),
    .clr_fault (clr_fault),
    .drv_mag   (drv_mag),
    .selGrn    (selGrn),
    .selYlw    (selYlw),
    .selBlu    (selBlu),
    .duty      (duty),
    .fault     (fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    hall      = 3'b101;
    brake_n   = 1'b1;
    dir       = 1'b0;
    clr_fault = 1'b0;
    drv_mag   = 12'h123;
    tick(3);
    check("rst_sel", 32'(sel_v), 32'h00);
    check("rst_fault", 32'(fault), 32'h0);
    check("rst_duty", 32'(duty), 32'h000);

    // Release: hall 101 first sampled at edge 1, driven at edge 7
    rst = 1'b0;
    tick(6);
    check("boot_e6_sel", 32'(sel_v), 32'h00);
    tick(1);
    check("boot_e7_sel", 32'(sel_v), 32'b011000);
    check("boot_duty", 32'(duty), 32'h448);

    // Step 101->100 with dead-time
    hall = 3'b100;
    tick(6);
    check("step_e6_sel", 32'(sel_v), 32'b011000);
    tick(1);
    check("step_e7_dead", 32'(sel_v), 32'h00);
    tick(3);
    check("step_e10_dead", 32'(sel_v), 32'h00);
    tick(1);
    check("step_e11_sel", 32'(sel_v), 32'b010010);

    // One-cycle glitch must be filtered out
    hall = 3'b110;
    tick(1);
    hall = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_sel", 32'(sel_v), 32'b010010);
    end

    // Reverse direction
    dir = 1'b1;
    tick(1);
    check("rev_100_sel", 32'(sel_v), 32'b100001);
    hall = 3'b110;
    tick(11);
    check("rev_110_sel", 32'(sel_v), 32'b001001);
    drv_mag = 12'hFFF;
    tick(1);
    check("duty_max", 32'(duty), 32'h7FF);
    drv_mag = 12'h000;
    tick(1);
    check("duty_min", 32'(duty), 32'h400);

    // Brake in the middle of dead-time
    hall = 3'b010;
    tick(8);
    check("brk_pre_dead", 32'(sel_v), 32'h00);
    brake_n = 1'b0;
    tick(1);
    check("brk_sel", 32'(sel_v), 32'b111111);
    check("brk_duty", 32'(duty), 32'h600);
    tick(2);
    check("brk_hold_sel", 32'(sel_v), 32'b111111);
    brake_n = 1'b1;
    tick(1);
    check("brk_rel_dead0", 32'(sel_v), 32'h00);
    tick(3);
    check("brk_rel_dead3", 32'(sel_v), 32'h00);
    tick(1);
    check("brk_resume_sel", 32'(sel_v), 32'b011000);
    check("brk_resume_duty", 32'(duty), 32'h400);

    // Invalid Hall held: hall_q=000 at edge 6, counter hits 64 at edge 70
    hall = 3'b000;
    tick(69);
    check("bad_e69_fault", 32'(fault), 32'h0);
    tick(1);
    check("bad_e70_fault", 32'(fault), 32'h1);
    check("bad_sel", 32'(sel_v), 32'h00);
    check("bad_duty", 32'(duty), 32'h000);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    tick(1);
    check("clr_invalid_fault", 32'(fault), 32'h1);

    // Recover on a valid code
    dir  = 1'b0;
    hall = 3'b011;
    tick(8);
    check("pre_clr_fault", 32'(fault), 32'h1);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    check("clr_fault", 32'(fault), 32'h0);
    check("clr_dead_sel", 32'(sel_v), 32'h00);
    check("clr_duty", 32'(duty), 32'h400);
    tick(3);
    check("clr_dead3_sel", 32'(sel_v), 32'h00);
    tick(1);
    check("clr_resume_sel", 32'(sel_v), 32'b100001);

    // Walk to 101 along adjacent steps, then jump 101->110
    hall = 3'b001;
    tick(12);
    check("walk_001_sel", 32'(sel_v), 32'b001001);
    hall = 3'b101;
    tick(12);
    check("walk_101_sel", 32'(sel_v), 32'b011000);
    hall = 3'b110;
    tick(12);
`ifdef HALL_SEQ_CHECK_EN
    check("jump_fault", 32'(fault), 32'h1);
    check("jump_sel", 32'(sel_v), 32'h00);
`else
    check("jump_fault", 32'(fault), 32'h0);
    check("jump_sel", 32'(sel_v), 32'b000110);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
